// File: rtl/i2c_slave_read_bit.sv
// Single-bit I2C slave receiver: waits for a full SCL low->high transition and captures SDA at the rising edge.
// Optional macro I2C_SLAVE_READ_BIT_SYNC_EN adds a 2-flop synchronizer on scl/sda (idle value 1).
module i2c_slave_read_bit (
  input  logic clock,
  input  logic reset_n,
  input  logic go,
  input  logic scl,
  input  logic sda,
  output logic data,
  output logic finish
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOW  = 2'd1,
    WAIT_HIGH = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t state_r;
  state_t state_nxt_s;
  logic   scl_s;
  logic   sda_s;
  logic   data_nxt_s;
  logic   finish_nxt_s;

`ifdef I2C_SLAVE_READ_BIT_SYNC_EN
  logic [1:0] scl_sync_r;
  logic [1:0] sda_sync_r;

  // Two-stage synchronizers, reset to bus-idle high.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      scl_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
    end else begin
      scl_sync_r <= {scl_sync_r[0], scl};
      sda_sync_r <= {sda_sync_r[0], sda};
    end
  end

  assign scl_s = scl_sync_r[1];
  assign sda_s = sda_sync_r[1];
`else
  assign scl_s = scl;
  assign sda_s = sda;
`endif

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r <= IDLE;
      data    <= 1'b0;
      finish  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      data    <= data_nxt_s;
      finish  <= finish_nxt_s;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nxt_s  = state_r;
    data_nxt_s   = data;
    finish_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (go) begin
          state_nxt_s = scl_s ? WAIT_LOW : WAIT_HIGH;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT_LOW: begin
        if (!go) begin
          state_nxt_s = IDLE;
        end else if (!scl_s) begin
          state_nxt_s = WAIT_HIGH;
        end else begin
          state_nxt_s = WAIT_LOW;
        end
      end
      WAIT_HIGH: begin
        if (!go) begin
          state_nxt_s = IDLE;
        end else if (scl_s) begin
          // Capture while SCL is still high, before the master may move SDA.
          data_nxt_s   = sda_s;
          finish_nxt_s = 1'b1;
          state_nxt_s  = DONE;
        end else begin
          state_nxt_s = WAIT_HIGH;
        end
      end
      DONE: begin
        if (go) begin
          state_nxt_s = WAIT_LOW;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_slave_read_bit.sv
// Self-checking bench for i2c_slave_read_bit: per-cycle behavioural model plus directed scenarios
// with hand-computed captured-bit expectations.
module tb_i2c_slave_read_bit;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic go = 1'b0;
  logic scl = 1'b1;
  logic sda = 1'b1;
  logic data;
  logic finish;

  int checks = 0;
  int passed = 0;
  bit model_en = 1'b0;
  logic got[$];

  // model state: request armed, a low SCL already seen since arming, expected outputs
  bit   active = 1'b0;
  bit   low_seen = 1'b0;
  logic exp_data = 1'b0;
  logic exp_finish = 1'b0;
  logic scl_h1 = 1'b1, scl_h2 = 1'b1, sda_h1 = 1'b1, sda_h2 = 1'b1;

  i2c_slave_read_bit dut (
    .clock  (clock),
    .reset_n(reset_n),
    .go     (go),
    .scl    (scl),
    .sda    (sda),
    .data   (data),
    .finish (finish)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Compare the DUT against the model, then predict the response to the coming edge.
  initial begin
    logic s_scl, s_sda;
    forever begin
      @(negedge clock);
      if (model_en) begin
        chk("data", data, exp_data);
        chk("finish", finish, exp_finish);
        if (finish === 1'b1) got.push_back(data);
      end
      if (!reset_n) begin
        active = 1'b0; low_seen = 1'b0; exp_data = 1'b0; exp_finish = 1'b0;
        scl_h1 = 1'b1; scl_h2 = 1'b1; sda_h1 = 1'b1; sda_h2 = 1'b1;
      end else begin
`ifdef I2C_SLAVE_READ_BIT_SYNC_EN
        s_scl = scl_h2; s_sda = sda_h2;
        scl_h2 = scl_h1; sda_h2 = sda_h1;
        scl_h1 = scl; sda_h1 = sda;
`else
        s_scl = scl; s_sda = sda;
`endif
        if (exp_finish) begin
          // cycle after a capture: a held request always restarts with a fresh low phase
          active = go; low_seen = 1'b0; exp_finish = 1'b0;
        end else if (!active) begin
          active = go; low_seen = go && !s_scl;
        end else if (!go) begin
          active = 1'b0;
        end else if (!low_seen) begin
          low_seen = !s_scl;
        end else if (s_scl) begin
          exp_data = s_sda; exp_finish = 1'b1; active = 1'b0;
        end
      end
    end
  end

  task automatic wait_finish();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (finish === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    chk("finish_seen", ok, 1'b1);
  endtask

  task automatic do_bit(input logic b);
    go = 1'b1; scl = 1'b0;
    tick(1);
    sda = b;
    tick(1);
    scl = 1'b1;
    wait_finish();
    go = 1'b0;
    tick(1);
  endtask

  initial begin
    logic [31:0] word;
    int base;
    word = 32'h13579BDF;

    // reset
    reset_n = 1'b0;
    tick(2);
    model_en = 1'b1;
    chk("reset_data", data, 1'b0);
    chk("reset_finish", finish, 1'b0);
    reset_n = 1'b1;
    tick(2);

    // MSB-first bit stream
    base = got.size();
    for (int i = 31; i >= 0; i--) do_bit(word[i]);
    chk("stream_count", got.size() - base, 32);
    for (int i = 0; i < 32; i++) chk("stream_bit", got[base + i], word[31 - i]);
    tick(2);

    // SCL already high when go rises is not sampled
    base = got.size();
    scl = 1'b1; sda = 1'b1; go = 1'b1;
    tick(2);
    scl = 1'b0; sda = 1'b0;
    tick(2);
    scl = 1'b1;
    wait_finish();
    go = 1'b0;
    tick(2);
    chk("prehigh_count", got.size() - base, 1);
    chk("prehigh_data", got[base], 1'b0);

    // abort before SCL rises
    base = got.size();
    go = 1'b1; scl = 1'b0; sda = 1'b1;
    tick(2);
    go = 1'b0;
    tick(2);
    scl = 1'b1;
    tick(3);
    chk("abort_count", got.size() - base, 0);
    chk("abort_data_hold", data, 1'b0);
    do_bit(1'b1);
    tick(2);
    chk("after_abort_count", got.size() - base, 1);
    chk("after_abort_data", got[base], 1'b1);

    // back-to-back with go held high
    base = got.size();
    go = 1'b1; scl = 1'b0; sda = 1'b1;
    tick(2);
    scl = 1'b1;
    tick(2);
    scl = 1'b0; sda = 1'b0;
    tick(2);
    scl = 1'b1;
    tick(2);
    scl = 1'b0;
    tick(4);
    go = 1'b0;
    tick(2);
    chk("b2b_count", got.size() - base, 2);
    chk("b2b_first", got[base], 1'b1);
    chk("b2b_second", got[base + 1], 1'b0);

    // reset while waiting for SCL high
    do_bit(1'b1);
    tick(1);
    base = got.size();
    go = 1'b1; scl = 1'b0; sda = 1'b1;
    tick(2);
    reset_n = 1'b0;
    tick(1);
    scl = 1'b1;
    tick(1);
    chk("midreset_data", data, 1'b0);
    chk("midreset_finish", finish, 1'b0);
    reset_n = 1'b1; go = 1'b0;
    tick(3);
    chk("midreset_count", got.size() - base, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
